// File: rtl/ms_tick_gen.sv
// ms_tick_gen - millisecond timebase for the ladder-logic Timer rungs.
//
// Divides clk by DIV = CLK_HZ/TICK_HZ into a square wave `tick`. The low
// phase is LO = DIV-DIV/2 cycles and the high phase is HI = DIV/2 cycles. On
// every rising edge of tick it emits a one-cycle `tick_stb` and increments
// the free-running `ms_count`.
//
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   enable          1 = run, 0 = freeze (phase restarts cleanly from 0)
//   sync_clr        synchronous restart of phase and ms_count
//   match_val       compare value for match_stb
//   tick            ~50% square wave at TICK_HZ
//   tick_stb        one-clk pulse on the edge where tick rises
//   ms_count        tick rising edges since restart (wraps)
//   running         1 while the FSM is in RUN
//   match_stb       one-clk pulse when ms_count is loaded with match_val
//
// Optional build macro: TICKGEN_MATCH_EN enables the match comparator. When
// it is undefined, match_stb is tied 0 and match_val is ignored.
module ms_tick_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] match_val,
  output logic             tick,
  output logic             tick_stb,
  output logic [CNT_W-1:0] ms_count,
  output logic             running,
  output logic             match_stb
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int HI    = DIV / 2;
  localparam int LO    = DIV - HI;
  localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("ms_tick_gen: CLK_HZ/TICK_HZ must be >= 2");
  end

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt, cnt_d, cnt_step;
  logic               tick_d, stb_d, inc_d;
  logic [CNT_W-1:0]   ms_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= STOP;
      div_cnt  <= '0;
      tick     <= 1'b0;
      tick_stb <= 1'b0;
      ms_count <= '0;
    end else begin
      state_q  <= state_d;
      div_cnt  <= cnt_d;
      tick     <= tick_d;
      tick_stb <= stb_d;
      ms_count <= ms_d;
    end
  end

  // The edge that leaves STOP also counts. The first rise therefore lands
  // LO edges after enable is seen.
  always_comb begin
    state_d  = state_q;
    cnt_d    = div_cnt;
    tick_d   = tick;
    stb_d    = 1'b0;
    inc_d    = 1'b0;
    ms_d     = ms_count;
    cnt_step = (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + 1'b1;

    case (state_q)
      STOP:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = STOP;
      default: state_d = STOP;
    endcase

    if (sync_clr) begin
      state_d = enable ? RUN : STOP;
      cnt_d   = '0;
      tick_d  = 1'b0;
      ms_d    = '0;
    end else if (enable) begin
      cnt_d  = cnt_step;
      tick_d = (cnt_step >= DIV_W'(LO));
      if (cnt_step == DIV_W'(LO)) begin
        stb_d = 1'b1;
        inc_d = 1'b1;
        ms_d  = ms_count + 1'b1;
      end
    end else if (state_q == RUN) begin
      // Dropping enable abandons any partial high phase. Downstream edge
      // detectors never see a resumed, spurious rise.
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  assign running = (state_q == RUN);

`ifdef TICKGEN_MATCH_EN
  // Only a counting increment can match. Loads of 0 from sync_clr or reset
  // do not produce a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      match_stb <= 1'b0;
    else
      match_stb <= inc_d && !sync_clr && (ms_d == match_val);
  end
`else
  assign match_stb = 1'b0;
  logic unused_match;
  assign unused_match = ^{match_val, inc_d};
`endif

endmodule

// File: tb/tb_ms_tick_gen.sv
// Self-checking bench for ms_tick_gen at CLK_HZ=10, TICK_HZ=1, CNT_W=4.
// This gives DIV=10, LO=5 and HI=5.
module tb_ms_tick_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       sync_clr;
  logic [3:0] match_val;
  logic       tick, tick_stb, running, match_stb;
  logic [3:0] ms_count;

  ms_tick_gen #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync_clr(sync_clr),
    .match_val(match_val), .tick(tick), .tick_stb(tick_stb),
    .ms_count(ms_count), .running(running), .match_stb(match_stb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, clr, tick, stb, run, mstb;
    logic [3:0] ms;
    string      name;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[25];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic mexp(input logic stb, input logic [3:0] ms);
`ifdef TICKGEN_MATCH_EN
    return stb && (ms == 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one edge's inputs, queue the expectation, then pop and compare it
  // once the DUT has registered the edge.
  task automatic step(input vec_t v);
    vec_t e;
    enable   = v.en;
    sync_clr = v.clr;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk({e.name, ".tick"},    {3'b0, tick},      {3'b0, e.tick});
      chk({e.name, ".stb"},     {3'b0, tick_stb},  {3'b0, e.stb});
      chk({e.name, ".ms"},      ms_count,          e.ms);
      chk({e.name, ".running"}, {3'b0, running},   {3'b0, e.run});
      chk({e.name, ".match"},   {3'b0, match_stb}, {3'b0, e.mstb});
    end
  endtask

  task automatic edge_exp(input string nm, input logic en, input logic clr,
                          input logic tk, input logic stb, input logic [3:0] ms,
                          input logic run);
    vec_t v;
    v.name = nm; v.en = en; v.clr = clr; v.tick = tk; v.stb = stb;
    v.ms = ms; v.run = run; v.mstb = mexp(stb, ms);
    step(v);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".tick"},    {3'b0, tick},      4'd0);
    chk({nm, ".stb"},     {3'b0, tick_stb},  4'd0);
    chk({nm, ".ms"},      ms_count,          4'd0);
    chk({nm, ".running"}, {3'b0, running},   4'd0);
    chk({nm, ".match"},   {3'b0, match_stb}, 4'd0);
  endtask

  initial begin
    // Edge e after reset release with enable held. Phase = e mod 10.
    // The rise is at phase 5, and the count increments at edges 5, 15 and 25.
    for (int e = 1; e <= 25; e++) begin
      tbl[e-1].name = $sformatf("run_e%0d", e);
      tbl[e-1].en   = 1'b1;
      tbl[e-1].clr  = 1'b0;
      tbl[e-1].tick = (e % 10) >= 5;
      tbl[e-1].stb  = (e % 10) == 5;
      tbl[e-1].ms   = 4'((e + 5) / 10);
      tbl[e-1].run  = 1'b1;
      tbl[e-1].mstb = mexp(tbl[e-1].stb, tbl[e-1].ms);
    end

    rst = 1'b1; enable = 1'b0; sync_clr = 1'b0; match_val = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i]);

    // Restart the phase with sync_clr while ms_count=3.
    edge_exp("clr_edge", 1, 1, 0, 0, 4'd0, 1);
    for (int i = 1; i <= 4; i++) edge_exp($sformatf("clr_p%0d", i), 1, 0, 0, 0, 4'd0, 1);
    edge_exp("clr_rise", 1, 0, 1, 1, 4'd1, 1);

    // Drop enable during the high phase, then re-enable.
    edge_exp("hi_p6", 1, 0, 1, 0, 4'd1, 1);
    edge_exp("drop", 0, 0, 0, 0, 4'd1, 0);
    edge_exp("stop1", 0, 0, 0, 0, 4'd1, 0);
    edge_exp("stop2", 0, 0, 0, 0, 4'd1, 0);
    for (int i = 1; i <= 4; i++) edge_exp($sformatf("reen_p%0d", i), 1, 0, 0, 0, 4'd1, 1);
    edge_exp("reen_rise", 1, 0, 1, 1, 4'd2, 1);

    // Run 15 periods with ms_count=2 at phase 5. The 14th strobe wraps 15->0.
    for (int k = 1; k <= 150; k++) begin
      int ph;
      ph = (5 + k) % 10;
      edge_exp($sformatf("wrap_k%0d", k), 1, 0, ph >= 5, ph == 5,
               4'((2 + k / 10) % 16), 1);
    end

    // Apply an asynchronous reset during the high phase. Outputs must clear
    // before the next edge.
    edge_exp("pre_rst", 1, 0, 1, 0, 4'd1, 1);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 4; i++) edge_exp($sformatf("post_p%0d", i), 1, 0, 0, 0, 4'd0, 1);
    edge_exp("post_rise", 1, 0, 1, 1, 4'd1, 1);

    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
